// File: rtl/braille_pkg.sv
// Shared types and constants for the Braille quiz controller: FSM states, widths, dot table.
package braille_pkg;

  localparam int DOT_W = 6;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHOW,
    RESULT,
    DONE
  } state_t;

  // Index 0..15 = a..p; bit0 = dot1. k..p reuse a..f with dot3 added.
  localparam logic [DOT_W-1:0] DOT_TABLE [16] = '{
    6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B, 6'h13,
    6'h0A, 6'h1A, 6'h05, 6'h07, 6'h0D, 6'h1D, 6'h15, 6'h0F
  };

endpackage

// File: rtl/braille_encoder.sv
// Letter index to 6-dot Braille cell lookup; purely combinational, zero latency,
// no flow control.
module braille_encoder
  import braille_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [DOT_W-1:0] dots
);

  assign dots = DOT_TABLE[idx];

endmodule

// File: rtl/braille_quiz_ctrl.sv
// Braille quiz session controller: fetches a random letter, shows its cell, scores the answer.
// Latency: game_start edge to first valid target_dots is 3 cycles; no backpressure, inputs are edge events.
// Optional BRAILLE_RETRY_EN: one retry after a wrong first submit in each round.
module braille_quiz_ctrl
  import braille_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned RESULT_CYCLES  = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             game_start,
  input  logic             submit,
  input  logic [DOT_W-1:0] answer_dots,
  input  logic [IDX_W-1:0] rng_value,
  output logic             rng_start,
  output logic             rng_update,
  output logic [DOT_W-1:0] target_dots,
  output logic [IDX_W-1:0] target_idx,
  output logic             correct,
  output logic             wrong,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             done
);

  localparam logic [31:0]      TO_LAST     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      RES_LAST    = 32'(RESULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROUNDS_LAST = CNT_W'(NUM_ROUNDS);

  state_t           state, state_nxt;
  logic             gs_q, sub_q;
  logic             gs_evt, sub_evt;
  logic [31:0]      timer;
  logic [DOT_W-1:0] enc_dots;
  logic             res_correct, res_retry;
  logic             start_session, latch_idx, timer_clr, enter_res;
  logic             ans_ok, res_ok_nxt, retry_nxt;
`ifdef BRAILLE_RETRY_EN
  logic             retry_used;
`endif

  braille_encoder u_enc (
    .idx  (target_idx),
    .dots (enc_dots)
  );

  assign gs_evt  = game_start & ~gs_q;
  assign sub_evt = submit & ~sub_q;
  assign ans_ok  = (answer_dots == enc_dots);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rng_update    = 1'b0;
    start_session = 1'b0;
    latch_idx     = 1'b0;
    timer_clr     = 1'b0;
    enter_res     = 1'b0;
    res_ok_nxt    = 1'b0;
    retry_nxt     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (gs_evt) begin
          start_session = 1'b1;
          state_nxt     = FETCH;
        end
      end
      FETCH: begin
        rng_update = 1'b1;
        state_nxt  = LATCH;
      end
      LATCH: begin
        latch_idx = 1'b1;
        timer_clr = 1'b1;
        state_nxt = SHOW;
      end
      SHOW: begin
        // Submit takes priority over a timeout landing in the same cycle.
        if (sub_evt) begin
          enter_res  = 1'b1;
          res_ok_nxt = ans_ok;
`ifdef BRAILLE_RETRY_EN
          retry_nxt  = ~ans_ok & ~retry_used;
`endif
          state_nxt  = RESULT;
        end else if (timer == TO_LAST) begin
          enter_res = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (timer == RES_LAST) begin
          timer_clr = 1'b1;
          if (res_retry)                  state_nxt = SHOW;
          else if (round == ROUNDS_LAST)  state_nxt = DONE;
          else                            state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gs_q        <= 1'b0;
      sub_q       <= 1'b0;
      timer       <= '0;
      score       <= '0;
      round       <= '0;
      target_idx  <= '0;
      res_correct <= 1'b0;
      res_retry   <= 1'b0;
    end else begin
      gs_q  <= game_start;
      sub_q <= submit;
      if (timer_clr || enter_res)                timer <= '0;
      else if (state == SHOW || state == RESULT) timer <= timer + 32'd1;
      if (start_session) begin
        score <= '0;
        round <= '0;
      end else if (enter_res && !retry_nxt) begin
        if (round != '1)               round <= round + 1'b1;
        if (res_ok_nxt && score != '1) score <= score + 1'b1;
      end
      if (latch_idx) target_idx <= rng_value;
      if (enter_res) begin
        res_correct <= res_ok_nxt;
        res_retry   <= retry_nxt;
      end
    end
  end

`ifdef BRAILLE_RETRY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        retry_used <= 1'b0;
    else if (latch_idx)              retry_used <= 1'b0;
    else if (enter_res && retry_nxt) retry_used <= 1'b1;
  end
`endif

  assign rng_start   = (state != IDLE);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign correct     = (state == RESULT) &&  res_correct;
  assign wrong       = (state == RESULT) && !res_correct;
  assign target_dots = (state == SHOW || state == RESULT) ? enc_dots : '0;

endmodule

// File: tb/tb_braille_quiz_ctrl.sv
// Directed bench for braille_quiz_ctrl with short timers (3 rounds, 20-cycle timeout, 4-cycle result).
module tb_braille_quiz_ctrl;

  logic       clk;
  logic       rst;
  logic       game_start;
  logic       submit;
  logic [5:0] answer_dots;
  logic [3:0] rng_value;
  logic       rng_start;
  logic       rng_update;
  logic [5:0] target_dots;
  logic [3:0] target_idx;
  logic       correct;
  logic       wrong;
  logic [7:0] score;
  logic [7:0] round;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  braille_quiz_ctrl #(
    .NUM_ROUNDS     (3),
    .TIMEOUT_CYCLES (20),
    .RESULT_CYCLES  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .game_start  (game_start),
    .submit      (submit),
    .answer_dots (answer_dots),
    .rng_value   (rng_value),
    .rng_start   (rng_start),
    .rng_update  (rng_update),
    .target_dots (target_dots),
    .target_idx  (target_idx),
    .correct     (correct),
    .wrong       (wrong),
    .score       (score),
    .round       (round),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {rng_start, rng_update, target_dots, target_idx, correct, wrong,
                score, round, busy, done}, 32'h0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; game_start = 1'b0; submit = 1'b0;
    answer_dots = 6'h00; rng_value = 4'd4;
    step(2);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    step(1);
    check("idle_rng_start", rng_start, 0);

    // Session A: correct, wrong, timeout
    game_start = 1'b1;
    check("cyc0_rng_update", rng_update, 0);
    step(1);
    game_start = 1'b0;
    check("cyc1_rng_update", rng_update, 1);
    check("cyc1_busy", busy, 1);
    check("cyc1_rng_start", rng_start, 1);
    step(1);
    check("cyc2_rng_update", rng_update, 0);
    check("cyc2_dots_blank", target_dots, 0);
    step(1);
    check("cyc3_idx", target_idx, 4);
    check("cyc3_dots_e", target_dots, 6'h11);
    check("cyc3_busy", busy, 1);

    answer_dots = 6'h11; submit = 1'b1; rng_value = 4'd3;
    step(1);
    submit = 1'b0;
    check("a1_correct", correct, 1);
    check("a1_wrong", wrong, 0);
    check("a1_score", score, 1);
    check("a1_round", round, 1);
    step(3);
    check("a1_correct_held", correct, 1);
    step(1);
    check("a1_next_fetch", rng_update, 1);
    check("a1_correct_drop", correct, 0);
    step(2);
    check("a2_dots_d", target_dots, 6'h19);

    answer_dots = 6'h09; submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("a2_wrong", wrong, 1);
    check("a2_score", score, 1);
`ifdef BRAILLE_RETRY_EN
    check("a2_retry_round", round, 0 + 1);
    step(4);
    check("a2_retry_no_fetch", rng_update, 0);
    check("a2_retry_dots", target_dots, 6'h19);
    submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("a2_second_wrong", wrong, 1);
`endif
    check("a2_round", round, 2);
    rng_value = 4'd9;
    step(4);
    check("a2_next_fetch", rng_update, 1);
    step(2);
    check("a3_dots_j", target_dots, 6'h1A);
    step(19);
    check("a3_pre_timeout", {correct, wrong}, 0);
    check("a3_pre_timeout_dots", target_dots, 6'h1A);
    step(1);
    check("a3_timeout_wrong", wrong, 1);
    check("a3_round", round, 3);
    check("a3_score", score, 1);
    step(4);
    check("a_done", done, 1);
    check("a_busy", busy, 0);
    check("a_done_rng_start", rng_start, 1);
    check("a_done_dots", target_dots, 0);
    answer_dots = 6'h1A; submit = 1'b1;
    step(2);
    submit = 1'b0;
    check("a_done_submit_score", score, 1);
    check("a_done_submit_done", done, 1);

    // Session B: all correct, submit coincident with timeout
    rng_value = 4'd3; game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    check("b_clear", {score, round, 7'd0, done, busy}, 32'h1);
    step(2);
    answer_dots = 6'h19; submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("b1_score", score, 1);
    rng_value = 4'd15;
    step(6);
    check("b2_dots_p", target_dots, 6'h0F);
    game_start = 1'b1;
    step(19);
    check("b2_gs_ignored", {busy, correct, wrong, 2'b0, target_dots}, {3'b100, 2'b0, 6'h0F});
    answer_dots = 6'h0F; submit = 1'b1;
    step(1);
    submit = 1'b0; game_start = 1'b0;
    check("b2_tie_correct", correct, 1);
    check("b2_tie_wrong", wrong, 0);
    check("b2_score", score, 2);
    rng_value = 4'd0;
    step(6);
    check("b3_dots_a", target_dots, 6'h01);
    answer_dots = 6'h01; submit = 1'b1;
    step(1);
    submit = 1'b0;
    step(4);
    check("b_done", {done, busy}, 2'b10);
    check("b_score", score, 3);
    check("b_round", round, 3);
    submit = 1'b1;
    step(2);
    submit = 1'b0;
    check("b_done_submit", {score, round}, {8'd3, 8'd3});
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    check("c_restart_clear", {score, round, done, busy}, 18'h1);

    // Reset in RESULT
    step(2);
    submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("c_in_result", correct, 1);
    rst = 1'b0;
    #1;
    check_all_zero("midreset_outputs");
    step(1);
    rst = 1'b1;
    step(1);
    check("midreset_idle", {rng_start, busy}, 0);

`ifdef BRAILLE_RETRY_EN
    rng_value = 4'd3; answer_dots = 6'h09; game_start = 1'b1;
    step(1);
    game_start = 1'b0;
    step(2);
    submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("r_first_wrong", {wrong, score, round}, 17'h10000);
    step(4);
    check("r_back_show", {target_idx, 2'b0, target_dots}, {4'd3, 2'b0, 6'h19});
    answer_dots = 6'h19; submit = 1'b1;
    step(1);
    submit = 1'b0;
    check("r_retry_correct", {correct, score, round}, {1'b1, 8'd1, 8'd1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/braille_quiz_ctrl.md
Name: braille_quiz_ctrl

Overview:
- Consumer of the 4-bit random character index produced by the random-number stage (rngenerator).
- Drives that stage's start/update controls, latches each index, encodes it to a 6-dot Braille cell for the display, and compares the learner's 6-switch answer on submit.
- Tracks score and round count, enforces a per-round timeout, and ends the session after NUM_ROUNDS rounds.

Parameters:
- NUM_ROUNDS, 10, rounds per session (1..255).
- TIMEOUT_CYCLES, 50000000, clocks allowed per answer before it is scored wrong (32-bit counter).
- RESULT_CYCLES, 25000000, clocks the correct/wrong indication is held.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- game_start  in  1  debounced level; rising edge starts a session.
- submit  in  1  debounced level; rising edge submits the answer.
- answer_dots  in  6  learner switches; bit n = dot n+1.
- rng_value  in  4  random index from rngenerator, registered there.
- rng_start  out  1  enables rngenerator's LFSR.
- rng_update  out  1  one-cycle load strobe to rngenerator.
- target_dots  out  6  Braille cell to display; bit n = dot n+1.
- target_idx  out  4  latched index (0=a .. 15=p).
- correct  out  1  high during RESULT when the answer matched.
- wrong  out  1  high during RESULT on mismatch or timeout.
- score  out  8  correct answers this session.
- round  out  8  rounds completed this session.
- busy  out  1  session in progress.
- done  out  1  session finished; held until the next game_start edge.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; edge-detect flops, timers and counters 0.
- Edge detect: game_start and submit each register their previous value; an event is "current & ~previous", one cycle long.
- rng_start: 1 in every state except IDLE, and stays 1 in DONE so the LFSR keeps running.
- IDLE: on game_start edge, clear score/round/done, set busy, go to FETCH.
- FETCH (1 cycle): rng_update=1, go to LATCH.
- LATCH (1 cycle): rng_value is now updated; capture it into target_idx, clear the timer, go to SHOW.
- SHOW:
  - target_dots = encode(target_idx); the timer increments each cycle.
  - On a submit edge, go to RESULT with correct = (answer_dots == target_dots).
  - Else, when the timer reaches TIMEOUT_CYCLES-1, go to RESULT with wrong=1.
  - Submit and timeout in the same cycle: submit wins.
- RESULT:
  - Hold correct/wrong for RESULT_CYCLES.
  - score increments once on entry if correct; round increments once on entry. Both saturate at 255.
  - On exit: if round == NUM_ROUNDS, go to DONE; else go to FETCH.
- DONE: busy=0, done=1, score/round held. A game_start edge behaves as in IDLE.
- Event filtering: submit edges outside SHOW are ignored. game_start edges while busy are ignored.
- Repeated indices across rounds are legal; no filtering.
- Encoding (hex, bit0 = dot1):
  - a..j = 01,03,09,19,11,0B,1B,13,0A,1A.
  - k..p = the a..f codes with dot3 added: 05,07,0D,1D,15,0F.
- target_dots is 0 outside SHOW/RESULT.
- Latency: game_start edge to first valid target_dots = 3 cycles (IDLE→FETCH→LATCH→SHOW).
- Reset asserted mid-session: immediate return to IDLE with all outputs 0, and rng_update deasserted.

Optional Feature:
- Macro: BRAILLE_RETRY_EN.
- Defined:
  - A wrong submit (not a timeout) on the first attempt of a round shows wrong for RESULT_CYCLES.
  - The block then returns to SHOW with the same target_idx and a cleared timer; round does not increment.
  - A second wrong submit or any timeout ends the round normally.
  - A per-round retry_used flag is cleared in LATCH.
- Undefined: every answer is final; no retry_used flop exists.

Decomposition:
- braille_pkg holds:
  - the state enum: IDLE, FETCH, LATCH, SHOW, RESULT, DONE;
  - the 16-entry dot-pattern constant table;
  - width constants DOT_W=6, IDX_W=4, CNT_W=8.
- Sub-module braille_encoder: combinational 4-bit index to 6-bit cell lookup from the package table; reusable by the display path.

Test Plan:
- Reset, then game_start edge → rng_update pulses exactly at cycle 1; rng_value=4 gives target_idx=4 and target_dots=0x11 at cycle 3; busy=1.
- In SHOW with target "d" (0x19): answer_dots=0x19 plus submit edge → correct=1 for RESULT_CYCLES, score=1, round=1, then a new FETCH.
- answer_dots=0x09 against target 0x19 → wrong=1, score unchanged, round increments.
- No submit for TIMEOUT_CYCLES (set to 20) → wrong=1 at cycle 20 of SHOW. Submit in that same cycle with the matching answer → correct=1 instead.
- NUM_ROUNDS=3, all answers correct → done=1, busy=0, score=3, round=3. A further submit is ignored. A new game_start edge clears the counters.
- Reset pulled low during RESULT → all outputs 0 at once, state IDLE. BRAILLE_RETRY_EN build: first wrong submit returns to SHOW with the same target; a second correct submit gives score+1 and round+1.
